// File: rtl/apb_completer_regs.sv
// -----------------------------------------------------------------------------
// apb_completer_regs
//
// APB3 completer holding a small bank of word registers behind a fixed base
// address. Every access phase is stretched by WAIT_STATES cycles before
// pready_o rises. Misaligned, out-of-window and read-only-target accesses are
// answered with pslverr_o. The top register is a read-only count of committed
// writes (it wraps).
//
// Ports
//   clk        in   1       clock, all state on rising edge
//   rst        in   1       asynchronous active-low reset
//   psel_i     in   1       APB select
//   penable_i  in   1       APB enable (access phase)
//   paddr_i    in   ADDR_W  byte address
//   pwrite_i   in   1       1 = write, 0 = read
//   pwdata_i   in   DATA_W  write data
//   pready_o   out  1       transfer completes this cycle
//   prdata_o   out  DATA_W  read data, non-zero only on a good read completion
//   pslverr_o  out  1       error response, only while pready_o=1
// -----------------------------------------------------------------------------
module apb_completer_regs #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                NUM_REGS    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic              pwrite_i,
  input  logic [DATA_W-1:0] pwdata_i,
  output logic              pready_o,
  output logic [DATA_W-1:0] prdata_o,
  output logic              pslverr_o
);

  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_IDX = NUM_REGS - 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  logic [0:0]        r_state;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_regs [NUM_REGS];

  // Decode of the captured request. The base is word aligned, so the low
  // offset bits equal the low address bits.
  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-3:0] w_idx_full;
  logic [IDX_W-1:0]  w_idx;
  logic              w_below;
  logic              w_misaligned;
  logic              w_out_of_range;
  logic              w_read_only;
  logic              w_err;
  logic              w_ready;
  logic              w_commit;
  logic [DATA_W-1:0] w_rdata;

  assign w_off          = r_addr - BASE_ADDR;
  assign w_idx_full     = w_off[ADDR_W-1:2];
  assign w_idx          = w_idx_full[IDX_W-1:0];
  assign w_below        = (r_addr < BASE_ADDR);
  assign w_misaligned   = (w_off[1:0] != 2'b00);
  assign w_out_of_range = (w_idx_full >= (ADDR_W-2)'(NUM_REGS));
  assign w_read_only    = r_write && (w_idx_full == (ADDR_W-2)'(CNT_IDX));
  assign w_err          = w_below || w_misaligned || w_out_of_range || w_read_only;

  // Completion is gated by the live psel/penable so a dropped select can
  // never produce a pready pulse.
  assign w_ready  = (r_state == S_ACCESS) && (r_count == '0) && psel_i && penable_i;
  assign w_commit = w_ready && r_write && !w_err;
  assign w_rdata  = r_regs[w_idx];

  assign pready_o  = w_ready;
  assign pslverr_o = w_ready && w_err;
  assign prdata_o  = (w_ready && !r_write && !w_err) ? w_rdata : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Only a setup phase starts a transfer; a stray penable is ignored.
          if (psel_i && !penable_i) begin
            r_state <= S_ACCESS;
            r_count <= CNT_W'(WAIT_STATES);
            r_addr  <= paddr_i;
            r_write <= pwrite_i;
            r_wdata <= pwdata_i;
          end
        end
        S_ACCESS: begin
          if (!psel_i) begin
            r_state <= S_IDLE;
            r_count <= '0;
          end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
          end else if (penable_i) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  // NOTE: the bank is a handful of flops, not a RAM macro, so it takes the
  // async reset and software always reads zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      for (int i = 0; i < CNT_IDX; i++) begin
        if (w_idx == IDX_W'(i)) begin
          r_regs[i] <= r_wdata;
        end
      end
      // Wraps naturally at 2^DATA_W.
      r_regs[CNT_IDX] <= r_regs[CNT_IDX] + 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_completer_regs.sv
// -----------------------------------------------------------------------------
// tb_apb_completer_regs
//
// Three completer instances: default parameters (d0), WAIT_STATES=0 (d1) and
// DATA_W=4 (d2). The stimulus process pushes the expected completion of each
// transfer into a scoreboard queue; a monitor pops and compares whenever any
// instance raises pready_o.
// -----------------------------------------------------------------------------
module tb_apb_completer_regs;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        psel    [3];
  logic        penable [3];
  logic [31:0] paddr   [3];
  logic        pwrite  [3];
  logic [31:0] pwdata  [3];

  logic        pready0, pready1, pready2;
  logic        pslverr0, pslverr1, pslverr2;
  logic [31:0] prdata0, prdata1;
  logic [3:0]  prdata2;

  apb_completer_regs u_d0 (
    .clk(clk), .rst(rst), .psel_i(psel[0]), .penable_i(penable[0]),
    .paddr_i(paddr[0]), .pwrite_i(pwrite[0]), .pwdata_i(pwdata[0]),
    .pready_o(pready0), .prdata_o(prdata0), .pslverr_o(pslverr0)
  );

  apb_completer_regs #(.WAIT_STATES(0)) u_d1 (
    .clk(clk), .rst(rst), .psel_i(psel[1]), .penable_i(penable[1]),
    .paddr_i(paddr[1]), .pwrite_i(pwrite[1]), .pwdata_i(pwdata[1]),
    .pready_o(pready1), .prdata_o(prdata1), .pslverr_o(pslverr1)
  );

  apb_completer_regs #(.DATA_W(4)) u_d2 (
    .clk(clk), .rst(rst), .psel_i(psel[2]), .penable_i(penable[2]),
    .paddr_i(paddr[2]), .pwrite_i(pwrite[2]), .pwdata_i(pwdata[2][3:0]),
    .pready_o(pready2), .prdata_o(prdata2), .pslverr_o(pslverr2)
  );

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void sample(input int d, output logic rdy, output logic err,
                                 output logic [31:0] data);
    rdy = 1'b0; err = 1'b0; data = '0;
    case (d)
      0: begin rdy = pready0; err = pslverr0; data = prdata0; end
      1: begin rdy = pready1; err = pslverr1; data = prdata1; end
      2: begin rdy = pready2; err = pslverr2; data = {28'b0, prdata2}; end
      default: ;
    endcase
  endfunction

  // Monitor: every completion on any instance must match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        logic rdy, err;
        logic [31:0] data;
        exp_t e;
        sample(d, rdy, err, data);
        if (rdy) begin
          if (sb_q.size() == 0) begin
            check("unexpected_pready", {31'b0, rdy}, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check({e.name, "_dut"}, d, e.dut);
            check({e.name, "_rdata"}, data, e.rdata);
            check({e.name, "_err"}, {31'b0, err}, {31'b0, e.err});
          end
        end
      end
    end
  end

  // Called at posedge+1. Issues setup, then access until pready (bounded),
  // and returns at posedge+1 after the completion edge with psel still high
  // so a following xfer is back-to-back.
  task automatic xfer(input int d, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd,
                      input logic exp_err, input int waits, input string name);
    exp_t e;
    int n;
    bit done;
    logic rdy, err;
    logic [31:0] data;
    psel[d] = 1'b1; penable[d] = 1'b0;
    paddr[d] = addr; pwrite[d] = wr; pwdata[d] = wdata;
    e.dut = d; e.rdata = (wr || exp_err) ? 32'd0 : exp_rd;
    e.err = exp_err; e.name = name;
    sb_q.push_back(e);
    @(posedge clk); #1;
    penable[d] = 1'b1;
    n = 0; done = 1'b0;
    while (!done && n < 16) begin
      @(negedge clk);
      n++;
      sample(d, rdy, err, data);
      if (rdy) done = 1'b1;
      else check({name, "_wait_quiet"}, {31'b0, err || (data != 0)}, 32'd0);
      @(posedge clk); #1;
    end
    check({name, "_latency"}, n, waits + 1);
    if (!done) begin psel[d] = 1'b0; penable[d] = 1'b0; end
  endtask

  task automatic idle();
    for (int d = 0; d < 3; d++) begin psel[d] = 1'b0; penable[d] = 1'b0; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rdy, err;
    logic [31:0] data;
    for (int d = 0; d < 3; d++) begin
      psel[d] = 0; penable[d] = 0; paddr[d] = 0; pwrite[d] = 0; pwdata[d] = 0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    sample(0, rdy, err, data);
    check("rst_pready", {31'b0, rdy}, 32'd0);
    check("rst_pslverr", {31'b0, err}, 32'd0);
    check("rst_prdata", data, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: basic write/read with one wait state
    xfer(0, 32'h4,  1'b1, 32'hDEADBEEF, 32'h0,        1'b0, 1, "t1_wr4");
    xfer(0, 32'h4,  1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 1, "t1_rd4");
    xfer(0, 32'h1C, 1'b0, 32'h0,        32'h1,        1'b0, 1, "t1_rdcnt");
    idle();
    @(posedge clk); #1;

    // 3: error accesses leave state untouched
    xfer(0, 32'h20, 1'b0, 32'h0,  32'h0, 1'b1, 1, "t3_rd_range");
    xfer(0, 32'h6,  1'b0, 32'h0,  32'h0, 1'b1, 1, "t3_rd_misal");
    xfer(0, 32'h1C, 1'b1, 32'h55, 32'h0, 1'b1, 1, "t3_wr_ro");
    xfer(0, 32'h24, 1'b1, 32'h77, 32'h0, 1'b1, 1, "t3_wr_range");
    xfer(0, 32'h1C, 1'b0, 32'h0,  32'h1, 1'b0, 1, "t3_rdcnt");
    xfer(0, 32'h4,  1'b0, 32'h0,  32'hDEADBEEF, 1'b0, 1, "t3_rd4");
    idle();
    @(posedge clk); #1;

    // 4: psel dropped during the wait cycle aborts the write
    psel[0] = 1'b1; penable[0] = 1'b0; paddr[0] = 32'hC; pwrite[0] = 1'b1;
    pwdata[0] = 32'h12345678;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    @(negedge clk);
    check("t4_wait_pready", {31'b0, pready0}, 32'd0);
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge clk);
    check("t4_abort_pready", {31'b0, pready0}, 32'd0);
    @(posedge clk); #1;
    xfer(0, 32'hC,  1'b0, 32'h0,        32'h0,        1'b0, 1, "t4_rdC");
    xfer(0, 32'h1C, 1'b0, 32'h0,        32'h1,        1'b0, 1, "t4_rdcnt");
    xfer(0, 32'hC,  1'b1, 32'h0BADF00D, 32'h0,        1'b0, 1, "t4_wrC");
    xfer(0, 32'hC,  1'b0, 32'h0,        32'h0BADF00D, 1'b0, 1, "t4_rdC2");
    xfer(0, 32'h1C, 1'b0, 32'h0,        32'h2,        1'b0, 1, "t4_rdcnt2");
    idle();
    @(posedge clk); #1;

    // 2: zero wait states, back-to-back transfers
    xfer(1, 32'h0,  1'b1, 32'h11111111, 32'h0,        1'b0, 0, "t2_wr0");
    xfer(1, 32'h8,  1'b1, 32'h22222222, 32'h0,        1'b0, 0, "t2_wr8");
    xfer(1, 32'h1C, 1'b0, 32'h0,        32'h2,        1'b0, 0, "t2_rdcnt");
    xfer(1, 32'h8,  1'b0, 32'h0,        32'h22222222, 1'b0, 0, "t2_rd8");
    xfer(1, 32'h0,  1'b0, 32'h0,        32'h11111111, 1'b0, 0, "t2_rd0");
    idle();
    @(posedge clk); #1;

    // 6: 4-bit counter wraps after 16 writes
    for (int i = 0; i < 17; i++) begin
      xfer(2, (i % 7) * 4, 1'b1, i & 32'hF, 32'h0, 1'b0, 1, "t6_wr");
    end
    xfer(2, 32'h1C, 1'b0, 32'h0, 32'h1, 1'b0, 1, "t6_rdcnt");
    xfer(2, 32'h0,  1'b0, 32'h0, 32'hE, 1'b0, 1, "t6_rd0");
    idle();
    @(posedge clk); #1;

    // 5a: reset during the wait cycle of a write
    psel[0] = 1'b1; penable[0] = 1'b0; paddr[0] = 32'h10; pwrite[0] = 1'b1;
    pwdata[0] = 32'h55;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    #2 rst = 1'b0;
    #1;
    sample(0, rdy, err, data);
    check("t5_rstwait_pready", {31'b0, rdy}, 32'd0);
    check("t5_rstwait_prdata", data, 32'd0);
    idle();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    xfer(0, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0, 1, "t5_rd10");
    xfer(0, 32'h1C, 1'b0, 32'h0, 32'h0, 1'b0, 1, "t5_rdcnt");
    xfer(0, 32'h4,  1'b1, 32'hA5, 32'h0, 1'b0, 1, "t5_wr4");
    idle();
    @(posedge clk); #1;

    // 5b: reset in the completion cycle of a read drops outputs at once
    psel[0] = 1'b1; penable[0] = 1'b0; paddr[0] = 32'h4; pwrite[0] = 1'b0;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    @(posedge clk); #1;
    check("t5_cmpl_pready", {31'b0, pready0}, 32'd1);
    check("t5_cmpl_prdata", prdata0, 32'hA5);
    #1 rst = 1'b0;
    #1;
    check("t5_async_pready", {31'b0, pready0}, 32'd0);
    check("t5_async_prdata", prdata0, 32'd0);
    idle();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    xfer(0, 32'h4,  1'b0, 32'h0, 32'h0, 1'b0, 1, "t5_rd4");
    xfer(0, 32'hC,  1'b0, 32'h0, 32'h0, 1'b0, 1, "t5_rdC");
    xfer(0, 32'h1C, 1'b0, 32'h0, 32'h0, 1'b0, 1, "t5_rdcnt2");
    idle();

    repeat (3) @(posedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
